// File: rtl/decompressor_top.sv
// LZ-style decompressor: literal bytes and copies out of a 4 KiB history window.
// Optional `DECOMP_ERROR_CHECK_EN adds a sticky error output for bad copy offsets.
module decompressor_top (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        control_word_in,
    input  logic        data_in_valid,
    output logic [7:0]  decompressed_byte,
    output logic        out_valid,
    output logic        decompressor_busy
`ifdef DECOMP_ERROR_CHECK_EN
    ,
    output logic        error
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LIT,
        S_PRIME,
        S_COPY
    } state_t;

    state_t      state;
    logic [7:0]  mem [4096];
    logic [7:0]  rdata;
    logic [11:0] wp;
    logic [11:0] rp;
    logic [3:0]  cnt;
    logic [7:0]  lit;
    logic        fwd;
    logic        we;
    logic [7:0]  wdata;
    logic [11:0] offset;

    assign offset = {data_in[15:12], data_in[7:0]};

    // fwd marks a read that collided with the write of the byte emitted last
    always_comb begin
        we    = 1'b0;
        wdata = lit;
        unique case (state)
            S_LIT:   we = 1'b1;
            S_COPY: begin
                we    = 1'b1;
                wdata = fwd ? decompressed_byte : rdata;
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (we)
            mem[wp] <= wdata;
        rdata <= mem[rp];
    end

    // offset 0 wraps naturally to 4096 in the 12-bit subtraction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            decompressed_byte <= 8'h00;
            out_valid         <= 1'b0;
            decompressor_busy <= 1'b0;
            wp                <= 12'd0;
            rp                <= 12'd0;
            cnt               <= 4'd0;
            lit               <= 8'h00;
            fwd               <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (data_in_valid) begin
                        decompressor_busy <= 1'b1;
                        if (control_word_in) begin
                            rp    <= wp - offset;
                            cnt   <= data_in[11:8];
                            state <= S_PRIME;
                        end else begin
                            lit   <= data_in[7:0];
                            state <= S_LIT;
                        end
                    end
                end
                S_LIT: begin
                    decompressed_byte <= wdata;
                    out_valid         <= 1'b1;
                    wp                <= wp + 12'd1;
                    decompressor_busy <= 1'b0;
                    state             <= S_IDLE;
                end
                S_PRIME: begin
                    rp    <= rp + 12'd1;
                    fwd   <= 1'b0;
                    state <= S_COPY;
                end
                S_COPY: begin
                    decompressed_byte <= wdata;
                    out_valid         <= 1'b1;
                    wp                <= wp + 12'd1;
                    fwd               <= (rp == wp);
                    rp                <= rp + 12'd1;
                    if (cnt == 4'd0) begin
                        decompressor_busy <= 1'b0;
                        state             <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DECOMP_ERROR_CHECK_EN
    logic [12:0] emitted;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            emitted <= 13'd0;
            error   <= 1'b0;
        end else begin
            if (we && !emitted[12])
                emitted <= emitted + 13'd1;
            if (state == S_IDLE && data_in_valid && control_word_in &&
                (offset == 12'd0 || {1'b0, offset} > emitted))
                error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decompressor_top.sv
// Scoreboard bench for decompressor_top: a history model predicts every byte,
// a negedge monitor pops and compares; item tasks check the cycle timing.
module tb_decompressor_top;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        control_word_in = 1'b0;
    logic        data_in_valid = 1'b0;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        decompressor_busy;
`ifdef DECOMP_ERROR_CHECK_EN
    logic        error;
`endif

    decompressor_top dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .data_in_valid     (data_in_valid),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .decompressor_busy (decompressor_busy)
`ifdef DECOMP_ERROR_CHECK_EN
        ,
        .error             (error)
`endif
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  hist[4096];
    logic [11:0] mwp = 12'd0;
    int          emitted = 0;
    logic        merr = 1'b0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_emit(input logic [7:0] b);
        exp_q.push_back(b);
        hist[mwp] = b;
        mwp = mwp + 12'd1;
        if (emitted < 4096)
            emitted++;
    endtask

    task automatic model_item(input logic ctrl, input logic [15:0] d);
        logic [11:0] off;
        logic [11:0] wp0;
        logic [11:0] src;
        int          len;
        if (!ctrl) begin
            model_emit(d[7:0]);
        end else begin
            off = {d[15:12], d[7:0]};
            len = int'(d[11:8]) + 1;
            if (off == 12'd0 || int'(off) > emitted)
                merr = 1'b1;
            wp0 = mwp;
            for (int i = 0; i < len; i++) begin
                src = wp0 - off + 12'(i);
                model_emit(hist[src]);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0)
                check("extra_byte", 16'(out_valid), 16'd0);
            else
                check("byte", 16'(decompressed_byte), 16'(exp_q.pop_front()));
        end
    end

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b0;
        data_in_valid = 1'b0;
        #1;
        check("rst_ov", 16'(out_valid), 16'd0);
        check("rst_busy", 16'(decompressor_busy), 16'd0);
        check("rst_byte", 16'(decompressed_byte), 16'd0);
`ifdef DECOMP_ERROR_CHECK_EN
        check("rst_err", 16'(error), 16'd0);
`endif
        exp_q.delete();
        mwp = 12'd0;
        emitted = 0;
        merr = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic send(input logic ctrl, input logic [15:0] d, input bit noise);
        int n;
        int t;
        n = ctrl ? int'(d[11:8]) + 2 : 1;
        t = 0;
        while (decompressor_busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100)
            check("busy_wait", 16'(decompressor_busy), 16'd0);
        model_item(ctrl, d);
        control_word_in = ctrl;
        data_in = d;
        data_in_valid = 1'b1;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        check("busy_acc", 16'(decompressor_busy), 16'd1);
        for (int e = 1; e <= n; e++) begin
            @(posedge clock);
            @(negedge clock);
            check("ov_t", 16'(out_valid), 16'(ctrl ? (e >= 2) : 1'b1));
            check("busy_t", 16'(decompressor_busy), 16'(e < n));
            if (noise && e < n) begin
                data_in = 16'($urandom);
                control_word_in = 1'($urandom);
                data_in_valid = 1'($urandom);
            end else begin
                data_in_valid = 1'b0;
            end
        end
`ifdef DECOMP_ERROR_CHECK_EN
        check("error", 16'(error), 16'(merr));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++)
            hist[i] = 8'h00;
        repeat (2) @(negedge clock);
        do_reset();
        send(1'b0, 16'h0041, 1'b0);
        send(1'b0, 16'hAB62, 1'b0);

        do_reset();
        send(1'b0, 16'h0061, 1'b0);
        send(1'b0, 16'h0062, 1'b0);
        send(1'b0, 16'h0063, 1'b0);
        send(1'b1, 16'h0203, 1'b0);

        send(1'b0, 16'h0078, 1'b0);
        send(1'b1, 16'h0F01, 1'b0);
        send(1'b1, 16'h0F03, 1'b1);
        send(1'b1, 16'h0402, 1'b0);

        model_item(1'b1, 16'h0F10);
        control_word_in = 1'b1;
        data_in = 16'h0F10;
        data_in_valid = 1'b1;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("b5_ov", 16'(out_valid), 16'd1);
        reset = 1'b0;
        #1;
        check("mid_ov", 16'(out_valid), 16'd0);
        check("mid_busy", 16'(decompressor_busy), 16'd0);
        check("mid_byte", 16'(decompressed_byte), 16'd0);
        check("mid_left", 16'(exp_q.size()), 16'd12);
        exp_q.delete();
        mwp = 12'd0;
        emitted = 0;
        merr = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("mid_hold", 16'(out_valid), 16'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < 4100; i++)
            send(1'b0, {8'h00, 8'((i * 37) + (i / 256))}, 1'b0);
        send(1'b1, 16'hFFFF, 1'b0);
        send(1'b1, 16'h0000, 1'b0);
        send(1'b1, 16'h0402, 1'b0);
        send(1'b1, 16'h1F05, 1'b0);

        do_reset();
        send(1'b0, 16'h0061, 1'b0);
        send(1'b0, 16'h0062, 1'b0);
        send(1'b0, 16'h0063, 1'b0);
        send(1'b1, 16'h0005, 1'b0);
        send(1'b0, 16'h0064, 1'b0);
        send(1'b1, 16'h0102, 1'b0);

        repeat (4) @(negedge clock);
        check("q_empty", 16'(exp_q.size()), 16'd0);
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decompressor_top.md
DECOMPRESSOR_TOP -- requirements
Module: decompressor_top

Interface
REQ-001 clock  input  1  sole clock; all sequential logic on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 data_in  input  16  compressed item; the literal byte, or a copy descriptor.
REQ-004 control_word_in  input  1  item type: 0 = literal, 1 = copy.
REQ-005 data_in_valid  input  1  item present; sampled only while decompressor_busy=0.
REQ-006 decompressed_byte  output  8  current output byte.
REQ-007 out_valid  output  1  decompressed_byte valid this cycle; one byte per high cycle.
REQ-008 decompressor_busy  output  1  high while an item is in progress; inputs ignored while high.

Function
REQ-009 Acceptance SHALL occur at a rising edge where data_in_valid=1 and decompressor_busy=0; decompressor_busy SHALL go high at that same edge.
REQ-010 Literal (control_word_in=0): byte = data_in[7:0]; data_in[15:8] ignored.
REQ-011 A literal accepted at edge k SHALL drive out_valid=1 and the byte from edge k+1 for exactly one cycle; decompressor_busy SHALL clear at edge k+1.
REQ-012 Copy (control_word_in=1): offset = {data_in[15:12], data_in[7:0]} (12 bits); length L = data_in[11:8]+1 (range 1..16).
REQ-013 A copy SHALL emit L bytes, the i-th (i=0..L-1) equal to history[wp-offset+i] mod 4096, where wp is the write pointer at acceptance.
REQ-014 A copy accepted at edge k SHALL emit its bytes on consecutive edges k+2..k+L+1, with out_valid high continuously; decompressor_busy SHALL clear at edge k+L+1.
REQ-015 Every emitted byte SHALL be written to a 4096-byte history buffer at wp; wp SHALL then increment modulo 4096.
REQ-016 Overlapping copies (offset < L, e.g. offset=1 run-length) SHALL reproduce bytes written earlier in the same copy; the read path SHALL forward in-flight writes.
REQ-017 offset=0 SHALL be treated as offset 4096, i.e. the oldest history byte.
REQ-018 data_in and control_word_in SHALL be registered at acceptance; later changes while busy SHALL have no effect.
REQ-019 out_valid SHALL be 0 whenever no byte is being emitted; decompressed_byte SHALL hold its last value.

Reset
REQ-020 Assertion (reset=0) SHALL immediately clear out_valid, decompressor_busy, decompressed_byte (8'h00), wp, and the internal state.
REQ-021 Reset mid-copy SHALL abort the copy with no further bytes; history buffer contents are not cleared.
REQ-022 The first acceptance SHALL be possible at the first rising edge after reset deasserts.

Configuration
REQ-023 Macro DECOMP_ERROR_CHECK_EN: when defined, adds output error (1 bit, reset 0).
REQ-024 When DECOMP_ERROR_CHECK_EN is defined, error SHALL be set sticky on acceptance of a copy whose offset is 0 or exceeds the total bytes emitted since reset (saturating at 4096); the copy still executes per REQ-013/REQ-017.
REQ-025 When DECOMP_ERROR_CHECK_EN is undefined, the error port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Literal: after reset, control_word_in=0, data_in=16'h0041 -> out_valid one cycle later with 8'h41, then busy low.
REQ-027 Copy: literals "a","b","c", then control_word_in=1, data_in=16'h0203 -> "abc" on three consecutive out_valid cycles starting two edges after acceptance.
REQ-028 Run-length: literal "x", then copy 16'h0F01 -> 16 consecutive 8'h78 bytes; busy clears with the last byte.
REQ-029 Busy ignore: change data_in/control_word_in and toggle data_in_valid during a 16-byte copy -> output unchanged; the next item is accepted only after busy falls.
REQ-030 Reset mid-copy and wrap: assert reset during byte 5 of a 16-byte copy -> outputs clear immediately, no further bytes; separately, emit 4100 literals, then copy offset 4095 -> wp wraps and the correct historical bytes are returned.
REQ-031 With DECOMP_ERROR_CHECK_EN defined: a copy with offset 5 after 3 bytes emitted -> error=1 and stays 1 until reset.
